multicycle_controller: RTL and testbench

- Sequencing FSM for a multicycle RV32I datapath. A single shared memory, ALU and register file are time-multiplexed across fetch, decode, execute, memory and writeback states.
- Generates every datapath select and enable each cycle, including ALU control decode.
- Includes a memory ready/request handshake so fetch and memory states stall for variable-latency memory.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal. Any other opcode flags illegal and refetches.

---
 rtl/multicycle_controller.sv | 145 ++++++++++++++
 tb/tb_multicycle_controller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM and datapath control decode for a multicycle RV32I core
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic [1:0] immsrc,
    output logic [2:0] alu_control,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t cur, nxt;
    logic [2:0] alu_dec;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cur <= state_t'(RESET_STATE);
        else        cur <= nxt;

    assign state = cur;

    assign immsrc = (op == OP_SW)  ? 2'b01 :
                    (op == OP_BEQ) ? 2'b10 :
                    (op == OP_JAL) ? 2'b11 : 2'b00;

    assign alu_dec = (funct3 == 3'b000) ? ((op[5] & funct7) ? 3'b001 : 3'b000) :
                     (funct3 == 3'b010) ? 3'b101 :
                     (funct3 == 3'b110) ? 3'b011 :
                     (funct3 == 3'b111) ? 3'b010 : 3'b000;

    always_comb begin
        nxt         = FETCH;
        mem_req     = 1'b0;
        memwrite    = 1'b0;
        adrsrc      = 1'b0;
        irwrite     = 1'b0;
        pcwrite     = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 2'b00;
        alusrcb     = 2'b00;
        resultsrc   = 2'b00;
        alu_control = 3'b000;
        illegal     = 1'b0;
        case (cur)
            FETCH: begin
                mem_req   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                // mem_ready is ignored while reset is held
                irwrite   = mem_ready & rst_n;
                pcwrite   = mem_ready & rst_n;
                nxt       = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                nxt     = (op == OP_LW || op == OP_SW) ? MEMADR :
                          (op == OP_R)   ? EXECR :
                          (op == OP_I)   ? EXECI :
                          (op == OP_BEQ) ? BEQ :
                          (op == OP_JAL) ? JAL : FETCH;
                illegal = !(op == OP_LW || op == OP_SW || op == OP_R ||
                            op == OP_I || op == OP_BEQ || op == OP_JAL);
            end
            MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                nxt     = (op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adrsrc  = 1'b1;
                nxt     = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                adrsrc   = 1'b1;
                nxt      = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alusrca     = 2'b10;
                alu_control = alu_dec;
                nxt         = ALUWB;
            end
            EXECI: begin
                alusrca     = 2'b10;
                alusrcb     = 2'b01;
                alu_control = alu_dec;
                nxt         = ALUWB;
            end
            ALUWB: regwrite = 1'b1;
            BEQ: begin
                alusrca     = 2'b10;
                alu_control = 3'b001;
                pcwrite     = zero;
            end
            JAL: begin
                alusrca = 2'b01;
                alusrcb = 2'b10;
                pcwrite = 1'b1;
                nxt     = ALUWB;
            end
            default: nxt = FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle checks of multicycle_controller via an expectation queue
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7, zero, mem_ready;
    logic       mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite, illegal;
    logic [1:0] alusrca, alusrcb, resultsrc, immsrc;
    logic [2:0] alu_control;
    logic [3:0] state;

    typedef struct {
        string       tag;
        logic [21:0] v;
    } exp_t;
    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
        .adrsrc(adrsrc), .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc), .immsrc(immsrc),
        .alu_control(alu_control), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Fixed per-state fields: {mem_req, memwrite, adrsrc, regwrite, alusrca, alusrcb, resultsrc}
    function automatic logic [9:0] base(input logic [3:0] st);
        case (st)
            4'd0:    return 10'b1_0_0_0_00_10_10;
            4'd1:    return 10'b0_0_0_0_01_01_00;
            4'd2:    return 10'b0_0_0_0_10_01_00;
            4'd3:    return 10'b1_0_1_0_00_00_00;
            4'd4:    return 10'b0_0_0_1_00_00_01;
            4'd5:    return 10'b1_1_1_0_00_00_00;
            4'd6:    return 10'b0_0_0_0_10_00_00;
            4'd7:    return 10'b0_0_0_0_10_01_00;
            4'd8:    return 10'b0_0_0_1_00_00_00;
            4'd9:    return 10'b0_0_0_0_10_00_00;
            4'd10:   return 10'b0_0_0_0_01_10_00;
            default: return 10'b0;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        return (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [21:0] pack_exp(input logic [3:0] st, input logic irw, input logic pcw,
                                             input logic [2:0] alu, input logic ill);
        logic [9:0] b;
        b = base(st);
        return {st, b[9:7], irw, pcw, b[6:0], imm_of(op), alu, ill};
    endfunction

    task automatic check();
        exp_t e;
        logic [21:0] act;
        e = q.pop_front();
        act = {state, mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
               alusrca, alusrcb, resultsrc, immsrc, alu_control, illegal};
        n_chk++;
        assert (act === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", e.tag, act, e.v);
        end
        n_chk++;
        assert ((!memwrite || mem_req) && !(pcwrite && regwrite)) else begin
            n_fail++;
            $error("FAIL %s_inv: observed memwrite=%b mem_req=%b pcwrite=%b regwrite=%b expected legal combo",
                   e.tag, memwrite, mem_req, pcwrite, regwrite);
        end
    endtask

    // Drive inputs, queue the expected outputs for this cycle, compare, then advance one clock
    task automatic step(input string tag, input logic [3:0] st, input logic mr, input logic z,
                        input logic irw, input logic pcw, input logic [2:0] alu, input logic ill);
        mem_ready = mr;
        zero = z;
        q.push_back('{tag, pack_exp(st, irw, pcw, alu, ill)});
        #1;
        check();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag);
        step(tag, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0);
    endtask

    task automatic decode(input string tag);
        step(tag, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic plain(input string tag, input logic [3:0] st, input logic pcw, input logic [2:0] alu);
        step(tag, st, 1'b1, 1'b0, 1'b0, pcw, alu, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; op = LW; funct3 = 3'b000; funct7 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        #12;
        step("reset", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        rst_n = 1'b1;
        // lw: 5 cycles
        op = LW;
        fetch("lw_f"); decode("lw_d"); plain("lw_adr", 4'd2, 0, 3'b000);
        plain("lw_rd", 4'd3, 0, 3'b000); plain("lw_wb", 4'd4, 0, 3'b000);
        // sw with 3 stall cycles
        op = SW;
        fetch("sw_f"); decode("sw_d"); plain("sw_adr", 4'd2, 0, 3'b000);
        for (int i = 0; i < 3; i++) step("sw_stall", 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        plain("sw_wr", 4'd5, 0, 3'b000);
        // R-type sub
        op = RT; funct3 = 3'b000; funct7 = 1'b1;
        fetch("sub_f"); decode("sub_d"); plain("sub_ex", 4'd6, 0, 3'b001); plain("sub_wb", 4'd8, 0, 3'b000);
        // addi with funct7 bit set still adds
        op = IT;
        fetch("addi_f"); decode("addi_d"); plain("addi_ex", 4'd7, 0, 3'b000); plain("addi_wb", 4'd8, 0, 3'b000);
        // slt, andi, or
        op = RT; funct3 = 3'b010; funct7 = 1'b0;
        fetch("slt_f"); decode("slt_d"); plain("slt_ex", 4'd6, 0, 3'b101); plain("slt_wb", 4'd8, 0, 3'b000);
        op = IT; funct3 = 3'b111;
        fetch("andi_f"); decode("andi_d"); plain("andi_ex", 4'd7, 0, 3'b010); plain("andi_wb", 4'd8, 0, 3'b000);
        op = RT; funct3 = 3'b110;
        fetch("or_f"); decode("or_d"); plain("or_ex", 4'd6, 0, 3'b011); plain("or_wb", 4'd8, 0, 3'b000);
        op = RT; funct3 = 3'b001;
        fetch("sll_f"); decode("sll_d"); plain("sll_ex", 4'd6, 0, 3'b000); plain("sll_wb", 4'd8, 0, 3'b000);
        // beq taken / not taken
        op = BQ; funct3 = 3'b000;
        fetch("beq1_f"); decode("beq1_d");
        step("beq1_ex", 4'd9, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0);
        fetch("beq0_f"); decode("beq0_d");
        step("beq0_ex", 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0);
        // jal
        op = JL;
        fetch("jal_f"); decode("jal_d"); plain("jal_ex", 4'd10, 1, 3'b000); plain("jal_wb", 4'd8, 0, 3'b000);
        // illegal opcode
        op = 7'b0000000;
        fetch("ill_f");
        step("ill_d", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        // fetch stall, then lw abandoned mid-MEMREAD by async reset
        op = LW;
        step("fstall", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        fetch("rlw_f"); decode("rlw_d"); plain("rlw_adr", 4'd2, 0, 3'b000);
        step("rlw_rd", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        #2;
        rst_n = 1'b0;
        step("rst_mid", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        rst_n = 1'b1;
        step("post_rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        fetch("post_f");
        decode("post_d");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
